lane_spawner: RTL and testbench
===============================

Name: lane_spawner

Overview:
- Drives the spawn side of the car interface for one road lane: SpawnEnable, SpawnX, SpawnY and Type for a fixed pool of car slots.
- Decides when each slot spawns, using a frame-based gap timer plus an LFSR for random spacing and car type.
- Retires slots when lane density drops.
- Sits between the level/game controller (Run, Density, Speed, FaceLeft, LaneY) and NUM_SLOTS car instances.

Parameters:
- NUM_SLOTS, 4, number of car slots driven; 1..4.
- LFSR_SEED, 16'hACE1, initial LFSR value; a value of 0 is forced to 16'h0001.
- GAP_RAND_BITS, 6, LFSR bits added to the minimum gap.

Ports:
- FrameClk  in  1  frame-rate clock (one edge per video frame)
- ResetN  in  1  synchronous, active-low reset
- Run  in  1  lane enable; low clears all slots
- Density  in  3  maximum active slots; values above NUM_SLOTS saturate to NUM_SLOTS
- Speed  in  3  lane speed, also routed to the cars; 0 means frozen lane
- FaceLeft  in  1  lane direction, also routed to the cars
- LaneY  in  10  lane top Y
- SpawnEnable  out  NUM_SLOTS  per-slot enable, bit i drives car i
- SpawnX  out  10  entry X, shared by all slots
- SpawnY  out  10  registered LaneY
- TypeBus  out  2*NUM_SLOTS  per-slot type, slot i at bits [2i+1:2i]
- ActiveCount  out  3  number of set SpawnEnable bits
- Full  out  1  ActiveCount >= saturated Density

Behaviour:
- Reset: while ResetN is low at a FrameClk edge:
  - SpawnEnable=0, TypeBus=0, ActiveCount=0, Full=0.
  - SpawnX=740, SpawnY=0, gap counter=0, FSM=IDLE, LFSR=seed.
- Registered every edge, independent of FSM state:
  - SpawnX = FaceLeft ? 740 (CAR_MAX_X+1) : 51 (CAR_MIN_X-CAR_WIDTH-1).
  - SpawnY = LaneY.
- Timing constraint: a car latches SpawnX on the first edge after its enable rises. SpawnX therefore reflects the FaceLeft value sampled one edge earlier. A FaceLeft change affects only subsequent spawns.
- LFSR:
  - 16-bit Galois, taps 16'hB400.
  - Advances once per edge while in SPAWNING or HOLD.
  - Never reaches 0.
- FSM states:
  - IDLE: all enables 0; gap counter=0. Run=1 moves to SPAWNING on the next edge.
  - SPAWNING:
    - If gap counter is nonzero, decrement it.
    - If gap counter is 0, Speed!=0 and ActiveCount<Density, then in the same edge:
      - set the lowest-index clear slot;
      - load its Type from LFSR[1:0];
      - reload the gap counter with MIN_GAP[Speed] + LFSR[GAP_RAND_BITS+1:2].
    - Speed=0: counter holds and no spawn occurs.
    - Go to HOLD when ActiveCount would reach Density after this edge.
  - HOLD:
    - No spawns; gap counter holds.
    - If Density < ActiveCount: clear the highest-index set slot, one slot per edge. TypeBus for that slot is unchanged.
    - If Density > ActiveCount: return to SPAWNING, counter unchanged.
- Run=0 in any state: next edge clears all enables, sets the counter to 0 and goes to IDLE. The LFSR is not reset.
- First spawn after IDLE exit is immediate, because the counter is 0.
- MIN_GAP table, indexed by Speed 1..7: 112, 56, 38, 28, 23, 19, 16 frames. This is ceil(112/Speed) and guarantees 8 px clearance at half-rate car motion.
- Gap counter is 8 bits; max 112+63=175, so no overflow.
- Simultaneous events, in priority order: ResetN > Run=0 > retire > spawn. A spawn and a retire never occur on the same edge.
- A Type bit changes only on that slot's spawn edge.
- ActiveCount and Full are registered and consistent with SpawnEnable on the same edge.

Decomposition:
- Package crossy_pkg holds:
  - CAR_WIDTH=48, CAR_MIN_X=100, CAR_MAX_X=739;
  - MIN_GAP lookup function;
  - lane_state_t enum {IDLE, SPAWNING, HOLD}.
- Sub-module lfsr16 (ports FrameClk, ResetN, Advance, Seed, Value). It is reused by other randomised blocks.

Test Plan:
- Spawn and spacing: ResetN low 2 edges, then Run=1, Density=2, Speed=2, FaceLeft=1.
  - Edge 2: SpawnEnable=0001, SpawnX=740, Type = LFSR_SEED-step value [1:0].
  - Slot 1 sets exactly 56+LFSR[7:2] edges later.
  - Then Full=1 and state is HOLD.
- Right-facing entry: FaceLeft=0, Speed=7, Density=4.
  - SpawnX=51.
  - Slots fill in order 0,1,2,3 with gaps of 16..79 edges.
  - ActiveCount steps 1..4.
- Frozen lane: Speed=0, Run=1 for 300 edges -> SpawnEnable stays 0. Then Speed=3 -> slot 0 sets on the next edge.
- Retire: Density drops 4->1 in HOLD -> slots 3, 2, 1 clear on three consecutive edges; slot 0 and all TypeBus bits are unchanged.
- Clear paths:
  - Run=0 with 3 active slots -> all enables 0 on the next edge and FSM is IDLE.
  - ResetN=0 mid-gap -> all outputs take reset values on the next edge.
- Seed edge case: LFSR_SEED=0 -> LFSR starts at 1. Type and gap sequence match the reference model, with no lock-up over 10000 edges.

Source files
------------

// File: rtl/crossy_pkg.sv
// Shared constants, lane FSM states and the minimum-gap table for the crossy game blocks.
package crossy_pkg;

  localparam int unsigned CAR_WIDTH = 48;
  localparam int unsigned CAR_MIN_X = 100;
  localparam int unsigned CAR_MAX_X = 739;

  // Entry points sit just outside the visible road on each side.
  localparam logic [9:0] SPAWN_X_LEFT  = 10'(CAR_MAX_X + 1);
  localparam logic [9:0] SPAWN_X_RIGHT = 10'(CAR_MIN_X - CAR_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SPAWNING, HOLD} lane_state_t;

  // ceil(112/Speed): keeps 8 px clearance between cars moving at half rate.
  function automatic logic [7:0] min_gap(input logic [2:0] speed);
    logic [7:0] gap;
    case (speed)
      3'd1:    gap = 8'd112;
      3'd2:    gap = 8'd56;
      3'd3:    gap = 8'd38;
      3'd4:    gap = 8'd28;
      3'd5:    gap = 8'd23;
      3'd6:    gap = 8'd19;
      3'd7:    gap = 8'd16;
      default: gap = 8'd0;
    endcase
    return gap;
  endfunction

endpackage

// File: rtl/lane_spawner_if.sv
// Lane controller <-> spawner bundle: lane controls in, per-slot spawn signals out.
interface lane_spawner_if #(
  parameter int unsigned NUM_SLOTS = 4
);
  logic                   Run;
  logic [2:0]             Density;
  logic [2:0]             Speed;
  logic                   FaceLeft;
  logic [9:0]             LaneY;
  logic [NUM_SLOTS-1:0]   SpawnEnable;
  logic [9:0]             SpawnX;
  logic [9:0]             SpawnY;
  logic [2*NUM_SLOTS-1:0] TypeBus;
  logic [2:0]             ActiveCount;
  logic                   Full;

  modport master (
    output Run, Density, Speed, FaceLeft, LaneY,
    input  SpawnEnable, SpawnX, SpawnY, TypeBus, ActiveCount, Full
  );

  modport slave (
    input  Run, Density, Speed, FaceLeft, LaneY,
    output SpawnEnable, SpawnX, SpawnY, TypeBus, ActiveCount, Full
  );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR stepping once per enabled frame; a zero seed is replaced by 1.
module lfsr16 #(
  parameter logic [15:0] Taps = 16'hB400
) (
  input  logic        FrameClk,
  input  logic        ResetN,
  input  logic        Advance,
  input  logic [15:0] Seed,
  output logic [15:0] Value
);

  logic [15:0] seed_safe;

  assign seed_safe = (Seed == 16'h0000) ? 16'h0001 : Seed;

  always_ff @(posedge FrameClk) begin
    if (!ResetN) begin
      Value <= seed_safe;
    end else if (Advance) begin
      Value <= {1'b0, Value[15:1]} ^ (Value[0] ? Taps : 16'h0000);
    end
  end

endmodule

// File: rtl/lane_spawner.sv
// Spawn controller for one road lane: paces car-slot spawns with a gap timer plus LFSR jitter
// and retires slots from the top when the lane density drops.
module lane_spawner
  import crossy_pkg::*;
#(
  parameter int unsigned NUM_SLOTS     = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int unsigned GAP_RAND_BITS = 6
) (
  input logic           FrameClk,
  input logic           ResetN,
  lane_spawner_if.slave lane
);

  localparam logic [2:0] SlotsMax = 3'(NUM_SLOTS);

  lane_state_t            state_q;
  logic [NUM_SLOTS-1:0]   enable_q, spawn_mask, retire_mask;
  logic [2*NUM_SLOTS-1:0] type_q, type_d;
  logic [7:0]             gap_q, gap_load;
  logic [2:0]             count_q, count_inc, sat_density;
  logic                   full_q, spawn_ok, found_free, found_used;
  logic [9:0]             spawn_x_q, spawn_y_q;
  logic [15:0]            lfsr_value;
  logic                   unused_lfsr;

  lfsr16 u_lfsr (
    .FrameClk (FrameClk),
    .ResetN   (ResetN),
    .Advance  (state_q != IDLE),
    .Seed     (LFSR_SEED),
    .Value    (lfsr_value)
  );

  assign unused_lfsr = ^lfsr_value[15:GAP_RAND_BITS+2];

  always_comb begin
    sat_density = (lane.Density > SlotsMax) ? SlotsMax : lane.Density;
    count_inc   = count_q + 3'd1;
    gap_load    = min_gap(lane.Speed) + 8'(lfsr_value[GAP_RAND_BITS+1:2]);
    spawn_ok    = (gap_q == 8'd0) && (lane.Speed != 3'd0) && (count_q < sat_density);
    spawn_mask  = '0;
    retire_mask = '0;
    type_d      = type_q;
    found_free  = 1'b0;
    found_used  = 1'b0;
    // Spawns fill the lowest free slot; retires drop the highest busy one.
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (!found_free && !enable_q[i]) begin
        spawn_mask[i]     = 1'b1;
        type_d[2*i +: 2]  = lfsr_value[1:0];
        found_free        = 1'b1;
      end
    end
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!found_used && enable_q[i]) begin
        retire_mask[i] = 1'b1;
        found_used     = 1'b1;
      end
    end
  end

  always_ff @(posedge FrameClk) begin
    if (!ResetN) begin
      state_q   <= IDLE;
      enable_q  <= '0;
      type_q    <= '0;
      gap_q     <= 8'd0;
      count_q   <= 3'd0;
      full_q    <= 1'b0;
      spawn_x_q <= SPAWN_X_LEFT;
      spawn_y_q <= 10'd0;
    end else begin
      spawn_x_q <= lane.FaceLeft ? SPAWN_X_LEFT : SPAWN_X_RIGHT;
      spawn_y_q <= lane.LaneY;
      if (!lane.Run) begin
        state_q  <= IDLE;
        enable_q <= '0;
        gap_q    <= 8'd0;
        count_q  <= 3'd0;
        full_q   <= (sat_density == 3'd0);
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= SPAWNING;
            full_q  <= (count_q >= sat_density);
          end
          SPAWNING: begin
            if (spawn_ok) begin
              enable_q <= enable_q | spawn_mask;
              type_q   <= type_d;
              gap_q    <= gap_load;
              count_q  <= count_inc;
              full_q   <= (count_inc >= sat_density);
              if (count_inc >= sat_density) state_q <= HOLD;
            end else begin
              // A frozen lane (Speed 0) also freezes the gap timer.
              if (gap_q != 8'd0 && lane.Speed != 3'd0) gap_q <= gap_q - 8'd1;
              full_q <= (count_q >= sat_density);
              if (count_q >= sat_density) state_q <= HOLD;
            end
          end
          HOLD: begin
            if (sat_density < count_q) begin
              enable_q <= enable_q & ~retire_mask;
              count_q  <= count_q - 3'd1;
              full_q   <= 1'b1;
            end else begin
              full_q <= (count_q >= sat_density);
              if (sat_density > count_q) state_q <= SPAWNING;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign lane.SpawnEnable = enable_q;
  assign lane.SpawnX      = spawn_x_q;
  assign lane.SpawnY      = spawn_y_q;
  assign lane.TypeBus     = type_q;
  assign lane.ActiveCount = count_q;
  assign lane.Full        = full_q;

endmodule

// File: tb/tb_lane_spawner.sv
// Bench for lane_spawner: directed lane scenarios with hand-derived checks, plus a reference
// model feeding an event scoreboard for both the default-seed and zero-seed instances.
module tb_lane_spawner;
  import crossy_pkg::*;

  typedef struct {
    int       state;
    bit [3:0] en;
    bit [7:0] typ;
    int       gap;
    bit [15:0] lfsr;
    int       cnt;
    bit       full;
    bit [9:0] x;
    bit [9:0] y;
  } m_t;

  typedef struct {
    int cyc;
    m_t s;
  } ev_t;

  logic       clk = 1'b0;
  logic       resetn, run, faceleft;
  logic [2:0] density, speed;
  logic [9:0] laney;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  m_t         m, m0, m_nx, m0_nx;
  ev_t        q[$], q0[$];
  logic [3:0] prev_en = 4'b0, prev_en0 = 4'b0;

  always #5 clk = ~clk;

  lane_spawner_if #(.NUM_SLOTS(4)) bus ();
  lane_spawner_if #(.NUM_SLOTS(4)) bus0 ();

  assign bus.Run       = run;
  assign bus.Density   = density;
  assign bus.Speed     = speed;
  assign bus.FaceLeft  = faceleft;
  assign bus.LaneY     = laney;
  assign bus0.Run      = run;
  assign bus0.Density  = density;
  assign bus0.Speed    = speed;
  assign bus0.FaceLeft = faceleft;
  assign bus0.LaneY    = laney;

  lane_spawner #(.NUM_SLOTS(4), .LFSR_SEED(16'hACE1), .GAP_RAND_BITS(6)) dut (
    .FrameClk (clk),
    .ResetN   (resetn),
    .lane     (bus)
  );

  lane_spawner #(.NUM_SLOTS(4), .LFSR_SEED(16'h0000), .GAP_RAND_BITS(6)) dut0 (
    .FrameClk (clk),
    .ResetN   (resetn),
    .lane     (bus0)
  );

  function automatic bit [15:0] galois(bit [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic m_t step(m_t c, bit [15:0] seed, logic rn, logic rr, logic [2:0] dens,
                              logic [2:0] spd, logic fl, logic [9:0] ly);
    m_t n;
    int sat;
    bit done;
    n = c;
    done = 1'b0;
    if (rn !== 1'b1) begin
      n.state = 0; n.en = 0; n.typ = 0; n.gap = 0; n.cnt = 0; n.full = 0;
      n.x = 10'd740; n.y = 10'd0; n.lfsr = (seed == 16'h0) ? 16'h0001 : seed;
      return n;
    end
    sat = (int'(dens) > 4) ? 4 : int'(dens);
    n.x = fl ? 10'd740 : 10'd51;
    n.y = ly;
    if (c.state != 0) n.lfsr = galois(c.lfsr);
    if (rr !== 1'b1) begin
      n.en = 0; n.gap = 0; n.state = 0;
    end else if (c.state == 0) begin
      n.state = 1;
    end else if (c.state == 1) begin
      if (c.gap > 0) begin
        if (spd != 0) n.gap = c.gap - 1;
      end else if (spd != 0 && c.cnt < sat) begin
        for (int i = 0; i < 4; i++) begin
          if (!done && !c.en[i]) begin
            n.en[i] = 1'b1; n.typ[2*i +: 2] = c.lfsr[1:0]; done = 1'b1;
          end
        end
        n.gap = (112 + int'(spd) - 1) / int'(spd) + int'((c.lfsr >> 2) & 16'h3F);
      end
    end else begin
      if (sat < c.cnt) begin
        for (int i = 3; i >= 0; i--) begin
          if (!done && c.en[i]) begin
            n.en[i] = 1'b0; done = 1'b1;
          end
        end
      end else if (sat > c.cnt) begin
        n.state = 1;
      end
    end
    n.cnt  = $countones(n.en);
    n.full = (n.cnt >= sat);
    if (rr === 1'b1 && c.state == 1 && n.cnt >= sat) n.state = 2;
    return n;
  endfunction

  always_comb m_nx  = step(m,  16'hACE1, resetn, run, density, speed, faceleft, laney);
  always_comb m0_nx = step(m0, 16'h0000, resetn, run, density, speed, faceleft, laney);

  // Model advances on the same edge as the DUTs; enable changes become scoreboard events.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    m   <= m_nx;
    m0  <= m0_nx;
    if (m_nx.en != m.en)   q.push_back('{cyc + 1, m_nx});
    if (m0_nx.en != m0.en) q0.push_back('{cyc + 1, m0_nx});
  end

  task automatic cmp_event(input string tag, input ev_t e, input logic [3:0] en,
                           input logic [7:0] typ, input logic [2:0] cnt, input logic full,
                           input logic [9:0] x, input logic [9:0] y);
    n_cmp++;
    if (e.cyc != cyc || e.s.en !== en || e.s.typ !== typ || 3'(e.s.cnt) !== cnt ||
        e.s.full !== full || e.s.x !== x || e.s.y !== y) begin
      n_bad++;
      $display("FAIL sb_%s: got cyc=%0d en=%b typ=%h cnt=%0d full=%b x=%0d y=%0d, required cyc=%0d en=%b typ=%h cnt=%0d full=%b x=%0d y=%0d",
               tag, cyc, en, typ, cnt, full, x, y, e.cyc, e.s.en, e.s.typ, e.s.cnt, e.s.full,
               e.s.x, e.s.y);
    end
  endtask

  always @(negedge clk) begin
    if (bus.SpawnEnable !== prev_en) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_dut: SpawnEnable went to %b at cyc %0d, required no change",
                 bus.SpawnEnable, cyc);
      end else begin
        cmp_event("dut", q.pop_front(), bus.SpawnEnable, bus.TypeBus, bus.ActiveCount,
                  bus.Full, bus.SpawnX, bus.SpawnY);
      end
    end
    prev_en <= bus.SpawnEnable;
  end

  always @(negedge clk) begin
    if (bus0.SpawnEnable !== prev_en0) begin
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_dut0: SpawnEnable went to %b at cyc %0d, required no change",
                 bus0.SpawnEnable, cyc);
      end else begin
        cmp_event("dut0", q0.pop_front(), bus0.SpawnEnable, bus0.TypeBus, bus0.ActiveCount,
                  bus0.Full, bus0.SpawnX, bus0.SpawnY);
      end
    end
    prev_en0 <= bus0.SpawnEnable;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"},   32'(bus.SpawnEnable), 32'h0);
    chk({tag, "_type"}, 32'(bus.TypeBus),     32'h0);
    chk({tag, "_cnt"},  32'(bus.ActiveCount), 32'h0);
    chk({tag, "_full"}, 32'(bus.Full),        32'h0);
    chk({tag, "_x"},    32'(bus.SpawnX),      32'd740);
    chk({tag, "_y"},    32'(bus.SpawnY),      32'd0);
  endtask

  initial begin
    int k;
    int lz;
    logic [3:0] prev;
    logic [7:0] saved_typ;
    logic [3:0] retire_exp [3];
    retire_exp = '{4'b0111, 4'b0011, 4'b0001};

    resetn = 1'b0; run = 1'b0; density = 3'd0; speed = 3'd0; faceleft = 1'b1; laney = 10'd123;
    tick(2);
    chk_reset("reset");
    chk("reset_lfsr_seed0", 32'(dut0.u_lfsr.Value), 32'h0001);

    // Spawn and spacing.
    resetn = 1'b1; run = 1'b1; density = 3'd2; speed = 3'd2;
    tick();
    chk("idle_exit_en", 32'(bus.SpawnEnable), 32'h0);
    tick();
    chk("first_spawn_en", 32'(bus.SpawnEnable), 32'b0001);
    chk("first_spawn_x", 32'(bus.SpawnX), 32'd740);
    chk("first_spawn_y", 32'(bus.SpawnY), 32'd123);
    chk("first_type", 32'(bus.TypeBus[1:0]), 32'b01);
    chk("first_cnt", 32'(bus.ActiveCount), 32'd1);
    chk("first_full", 32'(bus.Full), 32'd0);
    k = 0;
    while (bus.SpawnEnable[1] !== 1'b1 && k < 300) begin tick(); k++; end
    // Gap 56+56=112 loaded, counted down to 0, then the spawn edge.
    chk("slot1_gap", 32'(k), 32'd113);
    chk("slot1_en", 32'(bus.SpawnEnable), 32'b0011);
    chk("hold_full", 32'(bus.Full), 32'd1);
    chk("hold_state", 32'(dut.state_q), 32'(HOLD));

    // Right-facing entry, filling all four slots.
    run = 1'b0;
    tick();
    run = 1'b1; faceleft = 1'b0; speed = 3'd7; density = 3'd4;
    tick();
    chk("right_x", 32'(bus.SpawnX), 32'd51);
    tick();
    chk("right_slot0", 32'(bus.SpawnEnable), 32'b0001);
    for (int s = 1; s < 4; s++) begin
      prev = bus.SpawnEnable;
      k = 0;
      while (bus.SpawnEnable === prev && k < 200) begin tick(); k++; end
      chk_range("fill_gap", k, 17, 80);
      chk("fill_en", 32'(bus.SpawnEnable), (32'd1 << (s + 1)) - 32'd1);
      chk("fill_cnt", 32'(bus.ActiveCount), 32'(s + 1));
    end
    chk("fill_full", 32'(bus.Full), 32'd1);
    chk("fill_state", 32'(dut.state_q), 32'(HOLD));

    // Retire from the top, one slot per edge, types untouched.
    saved_typ = bus.TypeBus;
    density = 3'd1;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("retire_en", 32'(bus.SpawnEnable), 32'(retire_exp[s]));
      chk("retire_type", 32'(bus.TypeBus), 32'(saved_typ));
    end
    tick();
    chk("retire_settled", 32'(bus.SpawnEnable), 32'b0001);

    // Run=0 with three active slots.
    laney = 10'd300;
    density = 3'd3;
    k = 0;
    while (bus.ActiveCount !== 3'd3 && k < 400) begin tick(); k++; end
    chk("three_active", 32'(bus.SpawnEnable), 32'b0111);
    run = 1'b0;
    tick();
    chk("runoff_en", 32'(bus.SpawnEnable), 32'h0);
    chk("runoff_cnt", 32'(bus.ActiveCount), 32'h0);
    chk("runoff_state", 32'(dut.state_q), 32'(IDLE));

    // Frozen lane.
    run = 1'b1; speed = 3'd0; density = 3'd4;
    k = 0;
    repeat (300) begin
      tick();
      if (bus.SpawnEnable !== 4'b0000) k++;
    end
    chk("frozen_nonzero_edges", 32'(k), 32'd0);
    speed = 3'd3;
    tick();
    chk("unfreeze_en", 32'(bus.SpawnEnable), 32'b0001);

    // Reset mid-gap with FaceLeft low.
    tick(5);
    resetn = 1'b0;
    tick();
    chk_reset("midgap_reset");
    resetn = 1'b1;

    // Long run: both seeds track the model; zero-seed LFSR must never hit 0.
    lz = 0;
    for (int i = 0; i < 10000; i++) begin
      if (i % 700 == 0) begin
        density = 3'((i / 700) % 6);
        speed   = 3'((i / 700 + 3) % 8);
        faceleft = ~faceleft;
      end
      run = (i == 5000) ? 1'b0 : 1'b1;
      tick();
      if (dut0.u_lfsr.Value === 16'h0000) lz++;
    end
    chk("lfsr0_zero_edges", 32'(lz), 32'd0);
    tick(2);
    chk("sb_dut_drained", 32'(q.size()), 32'd0);
    chk("sb_dut0_drained", 32'(q0.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
